// File: rtl/regwrite_arbiter.sv
// Arbitrates the register-file write port between main-control writeback (req0) and a long-latency unit (req1).
// Latency: req0 writes 1 cycle after its pulse; req1 writes 2 cycles after transfer; a displaced req0 writes 1 cycle late.
// Backpressure: req0 has none (one-entry hold0 absorbs a displaced pulse); req1 uses valid/ready, with ready low while pend1 is full.
module regwrite_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [1:0] req0_dst,
    input  logic [2:0] req0_src,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_dst,
    input  logic [2:0] req1_src,
    input  logic [4:0] wr_reg,
    output logic [1:0] wr_sel,
    output logic [2:0] wr_src,
    output logic       wr_from,
    output logic       wr_en,
    output logic       err
);

    typedef struct packed {
        logic [1:0] dst;
        logic [2:0] src;
    } wreq_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       hold0_v;
    wreq_t      hold0_q;
    logic       pend1_v;
    wreq_t      pend1_q;
    logic [3:0] starve_cnt;
    logic       commit_v;

    wreq_t      live0;
    wreq_t      a_req;
    logic       a_v;
    logic       xfer1;
    logic       drop0;

    logic       nxt_commit_v;
    wreq_t      win_req;
    logic       win_from;
    logic       clr_hold;
    logic       ld_hold;
    logic       clr_pend;
    logic [3:0] nxt_cnt;

    assign live0      = '{dst: req0_dst, src: req0_src};
    assign a_v        = hold0_v | req0_valid;
    assign a_req      = hold0_v ? hold0_q : live0;
    // A live pulse that meets an occupied hold0 has nowhere to go.
    assign drop0      = req0_valid & hold0_v;
    assign req1_ready = reset & ~pend1_v;
    assign xfer1      = req1_valid & req1_ready;
    assign wr_en      = commit_v & (wr_reg != 5'd0);

    always_comb begin
        nxt_commit_v = 1'b0;
        win_req      = a_req;
        win_from     = 1'b0;
        clr_hold     = 1'b0;
        ld_hold      = 1'b0;
        clr_pend     = 1'b0;
        nxt_cnt      = starve_cnt;
        if (a_v && pend1_v) begin
            nxt_commit_v = 1'b1;
            if (starve_cnt == STARVE_LIM) begin
                win_req  = pend1_q;
                win_from = 1'b1;
                clr_pend = 1'b1;
                ld_hold  = req0_valid & ~hold0_v;
                nxt_cnt  = 4'd0;
            end else begin
                clr_hold = hold0_v;
                nxt_cnt  = starve_cnt + 4'd1;
            end
        end else if (a_v) begin
            nxt_commit_v = 1'b1;
            clr_hold     = hold0_v;
        end else if (pend1_v) begin
            nxt_commit_v = 1'b1;
            win_req      = pend1_q;
            win_from     = 1'b1;
            clr_pend     = 1'b1;
            nxt_cnt      = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold0_v    <= 1'b0;
            hold0_q    <= '0;
            pend1_v    <= 1'b0;
            pend1_q    <= '0;
            starve_cnt <= 4'd0;
            commit_v   <= 1'b0;
            wr_sel     <= 2'b00;
            wr_src     <= 3'b000;
            wr_from    <= 1'b0;
            err        <= 1'b0;
        end else begin
            commit_v   <= nxt_commit_v;
            starve_cnt <= nxt_cnt;
            if (nxt_commit_v) begin
                wr_sel  <= win_req.dst;
                wr_src  <= win_req.src;
                wr_from <= win_from;
            end
            if (ld_hold) begin
                hold0_v <= 1'b1;
                hold0_q <= live0;
            end else if (clr_hold) begin
                hold0_v <= 1'b0;
            end
            // Transfer only happens with pend1 empty, so it never collides with clr_pend.
            if (xfer1) begin
                pend1_v <= 1'b1;
                pend1_q <= '{dst: req1_dst, src: req1_src};
            end else if (clr_pend) begin
                pend1_v <= 1'b0;
            end
            if (drop0) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: a directed vector table followed by random traffic against a rule-level model.
// Latency: inputs change on the falling edge, outputs are compared 1 time unit later, state advances on the rising edge.
// Backpressure: the req1 driver holds dst/src and valid until a transfer is seen.
module tb_regwrite_arbiter;

    localparam int SM = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic [1:0] req0_dst = 2'b00;
    logic [2:0] req0_src = 3'b000;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [1:0] req1_dst = 2'b00;
    logic [2:0] req1_src = 3'b000;
    logic [4:0] wr_reg = 5'd0;
    logic [1:0] wr_sel;
    logic [2:0] wr_src;
    logic       wr_from;
    logic       wr_en;
    logic       err;

    regwrite_arbiter #(.STARVE_MAX(SM)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_dst   (req0_dst),
        .req0_src   (req0_src),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_dst   (req1_dst),
        .req1_src   (req1_src),
        .wr_reg     (wr_reg),
        .wr_sel     (wr_sel),
        .wr_src     (wr_src),
        .wr_from    (wr_from),
        .wr_en      (wr_en),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: pending requests kept as queues of at most one entry each.
    typedef struct {
        logic [1:0] dst;
        logic [2:0] src;
    } ent_t;

    ent_t       hq[$];
    ent_t       pq[$];
    int         cnt;
    logic       m_cv;
    logic [1:0] m_sel;
    logic [2:0] m_src;
    logic       m_from;
    logic       m_err;

    task automatic model_clear();
        hq.delete();
        pq.delete();
        cnt    = 0;
        m_cv   = 1'b0;
        m_sel  = 2'b00;
        m_src  = 3'b000;
        m_from = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_commit(input ent_t e, input logic from);
        m_cv   = 1'b1;
        m_sel  = e.dst;
        m_src  = e.src;
        m_from = from;
    endtask

    task automatic model_step();
        ent_t live;
        ent_t e;
        bit   have_a;
        bit   have_b;
        bit   accept;
        live.dst = req0_dst;
        live.src = req0_src;
        have_a   = (hq.size() != 0) || req0_valid;
        have_b   = (pq.size() != 0);
        accept   = req1_valid && (pq.size() == 0);
        if (req0_valid && hq.size() != 0) m_err = 1'b1;
        if (have_a && have_b && cnt == SM) begin
            e = pq.pop_front();
            model_commit(e, 1'b1);
            if (req0_valid && hq.size() == 0) hq.push_back(live);
            cnt = 0;
        end else if (have_a) begin
            if (hq.size() != 0) e = hq.pop_front();
            else e = live;
            model_commit(e, 1'b0);
            if (have_b) cnt++;
        end else if (have_b) begin
            e = pq.pop_front();
            model_commit(e, 1'b1);
            cnt = 0;
        end else begin
            m_cv = 1'b0;
        end
        if (accept) begin
            e.dst = req1_dst;
            e.src = req1_src;
            pq.push_back(e);
        end
    endtask

    function automatic logic [8:0] model_exp();
        return {m_cv && (wr_reg != 5'd0), m_sel, m_src, m_from,
                reset && (pq.size() == 0), m_err};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {wr_en, wr_sel, wr_src, wr_from, req1_ready, err};
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got en=%b sel=%b src=%b from=%b rdy=%b err=%b, expected en=%b sel=%b src=%b from=%b rdy=%b err=%b",
                     name, got[8], got[7:6], got[5:3], got[2], got[1], got[0],
                     exp[8], exp[7:6], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic rs, input logic r0v, input logic [1:0] r0d, input logic [2:0] r0s,
                         input logic r1v, input logic [1:0] r1d, input logic [2:0] r1s, input logic [4:0] wreg);
        @(negedge clk);
        reset      = rs;
        req0_valid = r0v;
        req0_dst   = r0d;
        req0_src   = r0s;
        req1_valid = r1v;
        req1_dst   = r1d;
        req1_src   = r1s;
        wr_reg     = wreg;
        if (!rs) model_clear();
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) model_step();
    endtask

    typedef struct {
        logic       rst;
        logic       r0v;
        logic [1:0] r0d;
        logic [2:0] r0s;
        logic       r1v;
        logic [1:0] r1d;
        logic [2:0] r1s;
        logic [4:0] wreg;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic r0v, input logic [1:0] r0d, input logic [2:0] r0s,
                                input logic r1v, input logic [1:0] r1d, input logic [2:0] r1s, input logic [4:0] wreg,
                                input logic en, input logic [1:0] sel, input logic [2:0] src, input logic from,
                                input logic rdy, input logic er);
        vec_t v;
        v.rst  = rst;
        v.r0v  = r0v;
        v.r0d  = r0d;
        v.r0s  = r0s;
        v.r1v  = r1v;
        v.r1d  = r1d;
        v.r1s  = r1s;
        v.wreg = wreg;
        v.exp  = {en, sel, src, from, rdy, er};
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic       r0v, r1v, rs, hold_r1;
        logic [1:0] r0d, r1d;
        logic [2:0] r0s, r1s;
        logic [4:0] wreg;
        int         since0;

        model_clear();
        // rst r0v r0d r0s | r1v r1d r1s | wreg || en sel src from rdy err
        // Reset, then an uncontended req0 with a one-cycle write.
        vecs.push_back(mk(0,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd0,  0,2'b00,3'b000,0,0,0));
        vecs.push_back(mk(0,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd0,  0,2'b00,3'b000,0,0,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd0,  0,2'b00,3'b000,0,1,0));
        vecs.push_back(mk(1,1,2'b01,3'b001, 0,2'b00,3'b000, 5'd9,  0,2'b00,3'b000,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd9,  1,2'b01,3'b001,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd9,  0,2'b01,3'b001,0,1,0));
        // Write to $ra, then a commit that resolves to $0.
        vecs.push_back(mk(1,1,2'b11,3'b100, 0,2'b00,3'b000, 5'd31, 0,2'b01,3'b001,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd31, 1,2'b11,3'b100,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd31, 0,2'b11,3'b100,0,1,0));
        vecs.push_back(mk(1,1,2'b00,3'b000, 0,2'b00,3'b000, 5'd0,  0,2'b11,3'b100,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd0,  0,2'b00,3'b000,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd0,  0,2'b00,3'b000,0,1,0));
        // Uncontended req1 transfer.
        vecs.push_back(mk(1,0,2'b00,3'b000, 1,2'b01,3'b010, 5'd5,  0,2'b00,3'b000,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd5,  0,2'b00,3'b000,0,0,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd5,  1,2'b01,3'b010,1,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd5,  0,2'b01,3'b010,1,1,0));
        // Starvation limit: legal gapped req0 lets pend1 win in the gap, so the limit is reached
        // only by back-to-back pulses; the 4th contended slot goes to req1 and displaces req0 into hold0.
        vecs.push_back(mk(1,0,2'b00,3'b000, 1,2'b10,3'b011, 5'd7,  0,2'b01,3'b010,1,1,0));
        vecs.push_back(mk(1,1,2'b00,3'b001, 0,2'b00,3'b000, 5'd7,  0,2'b01,3'b010,1,0,0));
        vecs.push_back(mk(1,1,2'b00,3'b001, 0,2'b00,3'b000, 5'd7,  1,2'b00,3'b001,0,0,0));
        vecs.push_back(mk(1,1,2'b00,3'b001, 0,2'b00,3'b000, 5'd7,  1,2'b00,3'b001,0,0,0));
        vecs.push_back(mk(1,1,2'b01,3'b101, 0,2'b00,3'b000, 5'd7,  1,2'b00,3'b001,0,0,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd7,  1,2'b10,3'b011,1,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd7,  1,2'b01,3'b101,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd7,  0,2'b01,3'b101,0,1,0));
        // Counter restarted from 0: the next contention goes to req0 again.
        vecs.push_back(mk(1,0,2'b00,3'b000, 1,2'b10,3'b011, 5'd7,  0,2'b01,3'b101,0,1,0));
        vecs.push_back(mk(1,1,2'b00,3'b001, 0,2'b00,3'b000, 5'd7,  0,2'b01,3'b101,0,0,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd7,  1,2'b00,3'b001,0,0,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd7,  1,2'b10,3'b011,1,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd7,  0,2'b10,3'b011,1,1,0));
        // Fill hold0 again, then a live req0 collides with it: dropped, err sticks.
        vecs.push_back(mk(1,0,2'b00,3'b000, 1,2'b11,3'b110, 5'd3,  0,2'b10,3'b011,1,1,0));
        vecs.push_back(mk(1,1,2'b00,3'b001, 0,2'b00,3'b000, 5'd3,  0,2'b10,3'b011,1,0,0));
        vecs.push_back(mk(1,1,2'b00,3'b001, 0,2'b00,3'b000, 5'd3,  1,2'b00,3'b001,0,0,0));
        vecs.push_back(mk(1,1,2'b00,3'b001, 0,2'b00,3'b000, 5'd3,  1,2'b00,3'b001,0,0,0));
        vecs.push_back(mk(1,1,2'b01,3'b111, 0,2'b00,3'b000, 5'd3,  1,2'b00,3'b001,0,0,0));
        vecs.push_back(mk(1,1,2'b10,3'b100, 0,2'b00,3'b000, 5'd3,  1,2'b11,3'b110,1,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd3,  1,2'b01,3'b111,0,1,1));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd3,  0,2'b01,3'b111,0,1,1));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd3,  0,2'b01,3'b111,0,1,1));
        // Reset the cycle after a req1 transfer: the request never writes.
        vecs.push_back(mk(1,0,2'b00,3'b000, 1,2'b01,3'b010, 5'd5,  0,2'b01,3'b111,0,1,1));
        vecs.push_back(mk(0,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd5,  0,2'b00,3'b000,0,0,0));
        vecs.push_back(mk(0,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd5,  0,2'b00,3'b000,0,0,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd5,  0,2'b00,3'b000,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd5,  0,2'b00,3'b000,0,1,0));
        vecs.push_back(mk(1,0,2'b00,3'b000, 0,2'b00,3'b000, 5'd5,  0,2'b00,3'b000,0,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].r0v, vecs[i].r0d, vecs[i].r0s,
                  vecs[i].r1v, vecs[i].r1d, vecs[i].r1s, vecs[i].wreg);
            check($sformatf("vec%0d", i), vecs[i].exp);
            advance();
        end

        // Random traffic, mostly legal req0 spacing with rare back-to-back pulses and resets.
        since0  = 2;
        hold_r1 = 1'b0;
        r1v     = 1'b0;
        r1d     = 2'b00;
        r1s     = 3'b000;
        for (int c = 0; c < 1500; c++) begin
            rs  = ($urandom_range(99) != 0);
            r0v = ((since0 >= 2) && ($urandom_range(99) < 40)) || ($urandom_range(99) < 3);
            r0d = 2'($urandom_range(3));
            r0s = 3'($urandom_range(7));
            if (!hold_r1) begin
                r1v = ($urandom_range(1) == 1);
                r1d = 2'($urandom_range(3));
                r1s = 3'($urandom_range(7));
            end
            wreg = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            drive(rs, r0v, r0d, r0s, r1v, r1d, r1s, wreg);
            check($sformatf("rand%0d", c), model_exp());
            hold_r1 = rs && r1v && !(pq.size() == 0);
            since0  = (rs && r0v) ? 1 : since0 + 1;
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
